// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one data-memory port between the
// CPU load/store unit and the FPGA I/O front-end. Aborts an access that the
// memory fails to acknowledge within TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i     CPU request, held until cpu_ack_o
//   cpu_ack_o/err_o/rdata_o           CPU one-cycle completion, error, read data
//   fpga_*                            same set for the FPGA front-end
//   mem_req_o/we_o/addr_o/wdata_o     memory strobe and latched request fields
//   mem_rdata_i, mem_ack_i            memory read data and completion
//   owner_o                           00 idle, 01 CPU, 10 FPGA
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  input  logic              fpga_req_i,
  input  logic              fpga_we_i,
  input  logic [ADDR_W-1:0] fpga_addr_i,
  input  logic [DATA_W-1:0] fpga_wdata_i,
  output logic              fpga_ack_o,
  output logic [DATA_W-1:0] fpga_rdata_o,
  output logic              fpga_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [1:0]        owner_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_FPGA = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          owner_q, owner_d;
  logic                last_fpga_q, last_fpga_d;  // 1: FPGA was granted last
  logic                cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic                fpga_ack_q, fpga_ack_d, fpga_err_q, fpga_err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, fpga_rdata_q, fpga_rdata_d;
  logic                grant_cpu, grant_fpga;
  logic                finish, fin_err;
  logic [DATA_W-1:0]   fin_rdata;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cnt_q        <= '0;
      owner_q      <= OWN_NONE;
      last_fpga_q  <= 1'b1;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      fpga_ack_q   <= 1'b0;
      fpga_err_q   <= 1'b0;
      fpga_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_fpga_q  <= last_fpga_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      fpga_ack_q   <= fpga_ack_d;
      fpga_err_q   <= fpga_err_d;
      fpga_rdata_q <= fpga_rdata_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_fpga_d  = last_fpga_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_rdata_d  = '0;
    fpga_ack_d   = 1'b0;
    fpga_err_d   = 1'b0;
    fpga_rdata_d = '0;
    finish       = 1'b0;
    fin_err      = 1'b0;
    fin_rdata    = '0;
    // On contention the requester not granted last wins
    grant_cpu    = cpu_req_i && (!fpga_req_i || last_fpga_q);
    grant_fpga   = fpga_req_i && !grant_cpu;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          mem_we_d    = cpu_we_i;
          mem_addr_d  = cpu_addr_i;
          mem_wdata_d = cpu_wdata_i;
          owner_d     = OWN_CPU;
        end else if (grant_fpga) begin
          mem_we_d    = fpga_we_i;
          mem_addr_d  = fpga_addr_i;
          mem_wdata_d = fpga_wdata_i;
          owner_d     = OWN_FPGA;
        end
        if (grant_cpu || grant_fpga) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // An ack on the final timeout cycle still counts as success
        if (mem_ack_i) begin
          finish    = 1'b1;
          fin_rdata = mem_we_q ? '0 : mem_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d   = 1'b1;
            cpu_err_d   = fin_err;
            cpu_rdata_d = fin_rdata;
          end else begin
            fpga_ack_d   = 1'b1;
            fpga_err_d   = fin_err;
            fpga_rdata_d = fin_rdata;
          end
        end
      end
      DONE: begin
        last_fpga_d = (owner_q == OWN_FPGA);
        owner_d     = OWN_NONE;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign owner_o      = owner_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign cpu_err_o    = cpu_err_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign fpga_ack_o   = fpga_ack_q;
  assign fpga_err_o   = fpga_err_q;
  assign fpga_rdata_o = fpga_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single data-memory port between the CPU load/store unit and the FPGA I/O front-end (keypad/LCD/seven-segment controller). The FPGA front-end writes operands and opcodes to fixed memory-mapped slots and reads results back. The CPU accesses the same memory while executing. This block serialises both requesters onto one memory port with round-robin fairness, returns read data with a one-cycle acknowledge, and aborts any access the memory fails to answer within a bounded time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum cycles in BUSY without `mem_ack` before abort (≥2)

- `clk` in 1: system clock
- `rst` in 1: reset; one clock, synchronous, active-high
- `cpu_req` in 1: CPU access request, held until `cpu_ack`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_W, `cpu_wdata` in DATA_W: request fields, stable while `cpu_req` is high
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_rdata` out DATA_W: read data, valid while `cpu_ack` is high
- `cpu_err` out 1: high with `cpu_ack` when the access timed out
- `fpga_req`, `fpga_we`, `fpga_addr`, `fpga_wdata`, `fpga_ack`, `fpga_rdata`, `fpga_err`: same as the CPU set, for the FPGA front-end
- `mem_req` out 1: memory access strobe, held until ack or abort
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: latched request fields
- `mem_rdata` in DATA_W: memory read data, sampled when `mem_ack` is high
- `mem_ack` in 1: memory completion, may arrive in the first cycle of `mem_req`
- `owner` out 2: 00 idle, 01 CPU, 10 FPGA (status/debug)

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one requester asserts `req`, grant it.
  - If both assert `req`, grant the one that was *not* granted last (`last` pointer).
  - On grant: latch `we`, `addr` and `wdata` into the `mem_*` registers, set `owner`, go to BUSY.
- **BUSY**
  - `mem_req` = 1 and the `mem_*` fields are held constant.
  - The timeout counter counts up from 0.
  - If `mem_ack` = 1: capture `mem_rdata` (reads only; writes return 0), go to DONE with `err` = 0.
  - If the counter reaches TIMEOUT−1 without `mem_ack`: go to DONE with `err` = 1 and rdata = 0.
- **DONE**
  - Assert the owner's `ack` (and its `err` if set) for exactly one cycle.
  - Drive rdata to the owner's `rdata` port.
  - Update `last` to the owner, clear `owner`, go to IDLE.
- **Non-owner outputs:** `ack`, `err` and `rdata` stay 0.
- **Request changes:** requester inputs are sampled only in IDLE. Changes to `req` or its fields while in BUSY or DONE are ignored.
- **Requester obligation:** deassert `req` in the cycle after seeing `ack`, or keep it high to request again. A re-request is arbitrated normally in the following IDLE cycle. Round robin then favours the other requester if it is waiting.
- **After reset:** `last` = FPGA, so the CPU wins the first simultaneous request.
- **Reset mid-transaction:** the access is abandoned with no ack to either requester. The memory must tolerate `mem_req` dropping.

## Timing
- **Reset values:** state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, all `ack`/`err`/`rdata` 0, `owner` 00, `last` FPGA, counter 0.
- **All outputs are registered.**
- **Cycle numbering:**
  - Request seen in IDLE at cycle 0.
  - `mem_req` high from cycle 1.
  - If `mem_ack` arrives at cycle k ≥ 1, `ack` pulses at cycle k+1 and IDLE resumes at k+2.
- **Latencies:**
  - Minimum request-to-ack latency: 2 cycles (zero-wait memory).
  - Minimum request-to-request spacing: 3 cycles.
- **Timeout:** with no `mem_ack`, `mem_req` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). `ack`+`err` pulse at cycle TIMEOUT+1.
- **`mem_ack` while not in BUSY:** ignored.
- **`mem_ack` on the final timeout cycle:** treated as success (`err` = 0).

## Test plan
- **Reset:** `rst` for 2 cycles with both requests high. Every output matches its reset value. First grant after release is CPU (`owner` = 01).
- **Single CPU read:** `cpu_req`=1, `cpu_we`=0, `cpu_addr`=280, memory returns `mem_ack` at cycle 1 with `mem_rdata`=0x0000002A. `mem_addr`=280 at cycle 1. `cpu_ack`=1 and `cpu_rdata`=0x2A at cycle 2 only. `fpga_ack` stays 0.
- **Contention fairness:** both requesters hold `req` continuously and the memory acks immediately. Grants alternate CPU, FPGA, CPU, FPGA, with `ack` pulses 3 cycles apart.
- **FPGA write:** `fpga_we`=1, `addr`=220, `wdata`=0x12, memory ack delayed to cycle 4. `mem_we`/`mem_addr`/`mem_wdata` are stable over cycles 1–4. `fpga_ack` at cycle 5 with `fpga_rdata`=0.
- **Timeout:** TIMEOUT=16, `mem_ack` never asserted. `mem_req` is high for cycles 1–16. `cpu_ack`=`cpu_err`=1 at cycle 17. Next request proceeds normally.
- **Reset mid-access:** `rst` pulsed at cycle 2 of BUSY. `mem_req` is 0 the next cycle, no ack is issued, and the state is IDLE.
